mux2to1_32bit: RTL and testbench

MUX2TO1_32BIT -- requirements
Module: mux2to1_32bit

---
 rtl/mux2to1_pkg.sv | 13 +
 rtl/mux2to1_core.sv | 29 ++
 rtl/mux2to1_32bit.sv | 93 +++++++++
 tb/tb_mux2to1_32bit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux2to1_pkg.sv
// Shared constants for the 2:1 mux block.
//   DEFAULT_WIDTH : default data path width
//   DEFAULT_CNT_W : default select-toggle counter width
//   SEL_DATA0/1   : select encodings for source 0 / source 1
package mux2to1_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    localparam logic SEL_DATA0 = 1'b0;
    localparam logic SEL_DATA1 = 1'b1;

endpackage

// File: rtl/mux2to1_core.sv
// Combinational 2:1 selector.
// Ports:
//   select  : 0 picks data_0, 1 picks data_1
//   data_0  : source 0
//   data_1  : source 1
//   mux_out : selected value, all-X in simulation when select is X/Z
module mux2to1_core
    import mux2to1_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             select,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    output logic [WIDTH-1:0] mux_out
);

    // An unknown select falls through to the default arm, so simulation
    // shows X; synthesis treats the default as don't-care.
    always_comb begin
        mux_out = {WIDTH{1'bx}};
        case (select)
            SEL_DATA0: mux_out = data_0;
            SEL_DATA1: mux_out = data_1;
            default:   mux_out = {WIDTH{1'bx}};
        endcase
    end

endmodule

// File: rtl/mux2to1_32bit.sv
// 2:1 mux with a combinational output, a one-cycle registered output with
// valid flag, and a saturating count of select changes.
// Optional feature: define MUX2TO1_PARITY_EN to add a registered parity
// bit (XOR of the value loaded into output_data_q).
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   select         : source select (0 -> data_0, 1 -> data_1)
//   data_0, data_1 : sources
//   in_valid       : qualifies the inputs for the registered path
//   output_data    : combinational mux result
//   output_data_q  : registered mux result, held while in_valid=0
//   out_valid      : output_data_q was loaded on the last edge
//   sel_toggle_cnt : select changes since reset, saturating
//   output_parity  : ^output_data_q (MUX2TO1_PARITY_EN only)
module mux2to1_32bit
    import mux2to1_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             select,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] output_data,
    output logic [WIDTH-1:0] output_data_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sel_toggle_cnt
`ifdef MUX2TO1_PARITY_EN
    ,
    output logic             output_parity
`endif
);

    logic [WIDTH-1:0] mux_out;
    logic             prev_sel;
    logic             sel_changed;
    logic             cnt_full;

    mux2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .select  (select),
        .data_0  (data_0),
        .data_1  (data_1),
        .mux_out (mux_out)
    );

    assign output_data = mux_out;

    // Registered data path: load on in_valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_data_q <= '0;
            out_valid     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                output_data_q <= mux_out;
            end
        end
    end

`ifdef MUX2TO1_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_parity <= 1'b0;
        end else if (in_valid) begin
            output_parity <= ^mux_out;
        end
    end
`endif

    // Toggle counter runs regardless of in_valid and sticks at all-ones.
    assign sel_changed = (select != prev_sel);
    assign cnt_full    = (sel_toggle_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel       <= SEL_DATA0;
            sel_toggle_cnt <= '0;
        end else begin
            prev_sel <= select;
            if (sel_changed && !cnt_full) begin
                sel_toggle_cnt <= sel_toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux2to1_32bit.sv
module tb_mux2to1_32bit;

    localparam int unsigned SMALL_CNT_W = 3;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        select   = 1'b0;
    logic [31:0] data_0   = '0;
    logic [31:0] data_1   = '0;
    logic        in_valid = 1'b0;

    logic [31:0] output_data;
    logic [31:0] output_data_q;
    logic        out_valid;
    logic [15:0] sel_toggle_cnt;
    logic [31:0] s_output_data;
    logic [31:0] s_output_data_q;
    logic        s_out_valid;
    logic [SMALL_CNT_W-1:0] s_sel_toggle_cnt;
`ifdef MUX2TO1_PARITY_EN
    logic        output_parity;
    logic        s_output_parity;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_q       = '0;
    logic        m_valid   = 1'b0;
    logic        m_last_sel = 1'b0;
    int          m_toggles = 0;

    mux2to1_32bit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .select         (select),
        .data_0         (data_0),
        .data_1         (data_1),
        .in_valid       (in_valid),
        .output_data    (output_data),
        .output_data_q  (output_data_q),
        .out_valid      (out_valid),
        .sel_toggle_cnt (sel_toggle_cnt)
`ifdef MUX2TO1_PARITY_EN
        ,
        .output_parity  (output_parity)
`endif
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    mux2to1_32bit #(
        .WIDTH (32),
        .CNT_W (SMALL_CNT_W)
    ) dut_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .select         (select),
        .data_0         (data_0),
        .data_1         (data_1),
        .in_valid       (in_valid),
        .output_data    (s_output_data),
        .output_data_q  (s_output_data_q),
        .out_valid      (s_out_valid),
        .sel_toggle_cnt (s_sel_toggle_cnt)
`ifdef MUX2TO1_PARITY_EN
        ,
        .output_parity  (s_output_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Model: what the registers must contain after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        = '0;
            m_valid    = 1'b0;
            m_last_sel = 1'b0;
            m_toggles  = 0;
        end else begin
            if (select != m_last_sel) m_toggles = m_toggles + 1;
            m_last_sel = select;
            m_valid    = in_valid;
            if (in_valid) m_q = select ? data_1 : data_0;
        end
    end

    // Compare process: every falling edge, inputs and registers are stable.
    always @(negedge clk) begin
        logic [31:0] exp_mux;
        exp_mux = select ? data_1 : data_0;
        check("comb", output_data, exp_mux);
        check("reg_q", output_data_q, m_q);
        check("valid", out_valid, m_valid);
        check("cnt16", sel_toggle_cnt, sat(m_toggles, 16));
        check("cnt_small", s_sel_toggle_cnt, sat(m_toggles, SMALL_CNT_W));
        check("small_q", s_output_data_q, m_q);
`ifdef MUX2TO1_PARITY_EN
        check("parity", output_parity, ^m_q);
`endif
    end

    initial begin
        // Combinational path while held in reset and before any clocking matters
        select = 1'b0; data_0 = 32'h12345678; data_1 = 32'h87654321;
        #10;
        check("lit_sel0", output_data, 32'h12345678);
        select = 1'b1; data_0 = 32'hABCDEF01; data_1 = 32'h543210FF;
        #1;
        check("lit_sel1", output_data, 32'h543210FF);
        check("rst_q", output_data_q, 32'h0);
        check("rst_valid", out_valid, 1'b0);

        // Release reset with a valid sample queued
        @(negedge clk); #1;
        in_valid = 1'b1; select = 1'b1; data_1 = 32'h543210FF;
        rst_n = 1'b1;
        #1;
        check("pre_edge_q", output_data_q, 32'h0);
        check("pre_edge_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("first_q", output_data_q, 32'h543210FF);
        check("first_valid", out_valid, 1'b1);

        // Hold while in_valid is low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            data_0 = $urandom; data_1 = $urandom;
            @(posedge clk); #1;
            check("hold_q", output_data_q, 32'h543210FF);
            check("hold_valid", out_valid, 1'b0);
        end

        // Mid-operation reset clears immediately
        @(negedge clk); #1;
        select = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_q", output_data_q, 32'h0);
        check("async_cnt", sel_toggle_cnt, 16'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Toggle select every cycle with in_valid low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            select = ~select;
        end
        @(posedge clk); #1;
        check("lit_cnt5", sel_toggle_cnt, 16'd5);
        check("lit_small5", s_sel_toggle_cnt, 3'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            select = ~select;
        end
        @(posedge clk); #1;
        check("lit_cnt10", sel_toggle_cnt, 16'd10);
        check("lit_small_sat", s_sel_toggle_cnt, 3'd7);

`ifdef MUX2TO1_PARITY_EN
        @(negedge clk); #1;
        in_valid = 1'b1; select = 1'b0; data_0 = 32'h12345678;
        @(posedge clk); #1;
        check("lit_par1", output_parity, 1'b1);
        @(negedge clk); #1;
        data_0 = 32'h00000003;
        @(posedge clk); #1;
        check("lit_par0", output_parity, 1'b0);
`endif

        // Randomised traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            select   = 1'($urandom);
            in_valid = 1'($urandom);
            data_0   = $urandom;
            data_1   = $urandom;
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
